// File: rtl/copro_pkg.sv
// Shared types and constants for the float coprocessor dispatch stage.
// Defines the opcode set, the dispatcher state encoding and the FIFO payload layouts.
package copro_pkg;

    localparam int OPCODE_W = 11;

    localparam logic [OPCODE_W-1:0] OP_FADD = 11'd0;
    localparam logic [OPCODE_W-1:0] OP_FSUB = 11'd1;
    localparam logic [OPCODE_W-1:0] OP_FMUL = 11'd2;
    localparam logic [OPCODE_W-1:0] OP_FDIV = 11'd3;
    localparam logic [OPCODE_W-1:0] OP_LAST = 11'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } dispatch_state_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [31:0]         op0;
        logic [31:0]         op1;
    } cmd_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } res_t;

    localparam int CMD_W = $bits(cmd_t);
    localparam int RES_W = $bits(res_t);

    function automatic logic opcode_valid(input logic [OPCODE_W-1:0] op);
        return (op <= OP_LAST);
    endfunction

endpackage

// File: rtl/copro_fifo.sv
// Pointer/count FIFO with asynchronous reset; head data reads as zero while empty.
// Push when full and pop when empty are ignored.
module copro_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == CW'(0));
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Storage array, cleared on reset so no stale payload is ever observable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Read/write pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head output, forced to zero while empty.
    always_comb begin
        head_data = '0;
        if (!empty) begin
            head_data = mem_r[rd_ptr_r];
        end else begin
            head_data = '0;
        end
    end

endmodule

// File: rtl/copro_dispatch.sv
// Issue stage between the CPU user-instruction port and float_copro: buffers commands,
// issues one at a time, filters unsupported opcodes and queues results for the CPU.
module copro_dispatch #(
    parameter int CDEPTH  = 4,
    parameter int RDEPTH  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_opcode,
    input  logic [31:0] cmd_op0,
    input  logic [31:0] cmd_op1,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        copro_valid,
    output logic        copro_accept,
    output logic [10:0] copro_opcode,
    output logic [31:0] copro_op0,
    output logic [31:0] copro_op1,
    input  logic        copro_complete,
    input  logic [31:0] copro_result,
    output logic        busy
);

    import copro_pkg::*;

    localparam int             TW           = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT - 1);

    dispatch_state_t     state_r;
    dispatch_state_t     state_next_s;
    cmd_t                cmd_in_s;
    cmd_t                cmd_head_s;
    logic                cmd_full_s;
    logic                cmd_empty_s;
    logic                cmd_push_s;
    logic                cmd_pop_s;
    res_t                res_push_data_s;
    res_t                res_head_s;
    logic                res_full_s;
    logic                res_empty_s;
    logic                res_push_s;
    logic                load_s;
    logic                accept_s;
    logic [TW-1:0]       wait_cnt_r;
    logic                copro_valid_r;
    logic [OPCODE_W-1:0] opcode_r;
    logic [31:0]         op0_r;
    logic [31:0]         op1_r;

    assign cmd_in_s   = '{opcode: cmd_opcode, op0: cmd_op0, op1: cmd_op1};
    assign cmd_ready  = !cmd_full_s && !reset;
    assign cmd_push_s = cmd_valid && cmd_ready;

    copro_fifo #(.WIDTH(CMD_W), .DEPTH(CDEPTH)) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_push_s),
        .push_data (cmd_in_s),
        .pop       (cmd_pop_s),
        .head_data (cmd_head_s),
        .full      (cmd_full_s),
        .empty     (cmd_empty_s)
    );

    copro_fifo #(.WIDTH(RES_W), .DEPTH(RDEPTH)) u_res_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (res_push_s),
        .push_data (res_push_data_s),
        .pop       (res_ready),
        .head_data (res_head_s),
        .full      (res_full_s),
        .empty     (res_empty_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, FIFO pops/pushes and acknowledge decode.
    always_comb begin
        state_next_s    = state_r;
        cmd_pop_s       = 1'b0;
        res_push_s      = 1'b0;
        res_push_data_s = '0;
        load_s          = 1'b0;
        accept_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A completion seen while idle is left over from before a reset: flush it.
                if (copro_complete) begin
                    accept_s = 1'b1;
                end else if (!cmd_empty_s && !res_full_s) begin
                    cmd_pop_s = 1'b1;
                    if (opcode_valid(cmd_head_s.opcode)) begin
                        load_s       = 1'b1;
                        state_next_s = ST_ISSUE;
                    end else begin
                        res_push_s      = 1'b1;
                        res_push_data_s = '{err: 1'b1, data: 32'd0};
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (copro_complete) begin
                    res_push_s      = 1'b1;
                    res_push_data_s = '{err: 1'b0, data: copro_result};
                    state_next_s    = ST_ACK;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    res_push_s      = 1'b1;
                    res_push_data_s = '{err: 1'b1, data: 32'd0};
                    state_next_s    = ST_ACK;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_ACK: begin
                accept_s     = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // WAIT-cycle counter, zero on entry to WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= TW'(0);
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
        end else begin
            wait_cnt_r <= TW'(0);
        end
    end

    // Operand registers and the one-cycle issue strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_r      <= 11'd0;
            op0_r         <= 32'd0;
            op1_r         <= 32'd0;
            copro_valid_r <= 1'b0;
        end else begin
            if (load_s) begin
                opcode_r <= cmd_head_s.opcode;
                op0_r    <= cmd_head_s.op0;
                op1_r    <= cmd_head_s.op1;
            end
            copro_valid_r <= (state_next_s == ST_ISSUE);
        end
    end

    assign copro_valid  = copro_valid_r;
    assign copro_accept = accept_s;
    assign copro_opcode = opcode_r;
    assign copro_op0    = op0_r;
    assign copro_op1    = op1_r;
    assign res_valid    = !res_empty_s;
    assign res_data     = res_head_s.data;
    assign res_err      = res_head_s.err;
    assign busy         = (state_r != ST_IDLE) || !cmd_empty_s;

endmodule

// File: tb/tb_copro_dispatch.sv
// Directed bench for copro_dispatch with a float_copro stand-in and a result scoreboard.
module tb_copro_dispatch;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_opcode;
    logic [31:0] cmd_op0;
    logic [31:0] cmd_op1;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic        copro_valid;
    logic        copro_accept;
    logic [10:0] copro_opcode;
    logic [31:0] copro_op0;
    logic [31:0] copro_op1;
    logic        copro_complete = 1'b0;
    logic [31:0] copro_result = 32'd0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [32:0] exp_q[$];
    logic [32:0] sb_e;
    int valid_cnt = 0, acc_cnt = 0, rv_cnt = 0;
    int last_valid_cyc = -1, last_acc_cyc = -1, last_rise_cyc = -1;
    logic prev_rv = 1'b0;

    logic stub_hang = 1'b0;
    int   lat_ovr = 0;
    logic stub_run = 1'b0;
    int   stub_cnt = 0;

    copro_dispatch dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_op0(cmd_op0), .cmd_op1(cmd_op1),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .copro_valid(copro_valid), .copro_accept(copro_accept), .copro_opcode(copro_opcode),
        .copro_op0(copro_op0), .copro_op1(copro_op1), .copro_complete(copro_complete),
        .copro_result(copro_result), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input logic [10:0] op);
        case (op)
            11'd0:   return 3;
            11'd1:   return 2;
            11'd2:   return 5;
            11'd3:   return 5;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] fp_model(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 11'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 11'd1 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        if (op == 11'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        return a ^ {b[15:0], b[31:16]} ^ {21'd0, op};
    endfunction

    // float_copro stand-in: latches on copro_valid, completes t+1 cycles later, holds until accepted.
    always @(posedge clk) begin
        if (copro_complete && copro_accept) copro_complete <= 1'b0;
        if (copro_valid && !stub_hang) begin
            stub_run     <= 1'b1;
            stub_cnt     <= (lat_ovr != 0) ? lat_ovr : lat_of(copro_opcode);
            copro_result <= fp_model(copro_opcode, copro_op0, copro_op1);
        end else if (stub_run) begin
            if (stub_cnt == 1) begin
                copro_complete <= 1'b1;
                stub_run       <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_en, input logic [32:0] exp, output int acyc);
        int n = 0;
        acyc = -1;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_op0 = a; cmd_op1 = b;
        while (acyc < 0 && n < 2000) begin
            @(negedge clk);
            if (cmd_ready) acyc = cyc;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        check("send_accepted", acyc >= 0, 1'b1);
        if (acyc >= 0 && exp_en) exp_q.push_back(exp);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy || res_valid || copro_complete) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("idle_bound", n < maxc, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int a, a1, a2, v0, c0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = 11'd0; cmd_op0 = 32'd0; cmd_op1 = 32'd0;
        res_ready = 1'b1;

        // Background monitor: scoreboard pops, event timestamps, handshake exclusivity.
        fork
            forever begin
                @(negedge clk);
                if (!reset && res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_extra_result", exp_q.size(), 1);
                    end else begin
                        sb_e = exp_q.pop_front();
                        check("sb_data", res_data, sb_e[31:0]);
                        check("sb_err", res_err, sb_e[32]);
                    end
                end
                if (copro_valid) begin valid_cnt++; last_valid_cyc = cyc; end
                if (copro_accept) begin acc_cnt++; last_acc_cyc = cyc; end
                if (res_valid) rv_cnt++;
                if (res_valid && !prev_rv) last_rise_cyc = cyc;
                prev_rv = res_valid;
                check("valid_accept_excl", copro_valid & copro_accept, 1'b0);
            end
        join_none

        repeat (2) @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_copro_valid", copro_valid, 1'b0);
        check("rst_copro_accept", copro_accept, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_err", res_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_copro_opcode", copro_opcode, 11'd0);
        check("rst_copro_op0", copro_op0, 32'd0);
        check("rst_copro_op1", copro_op1, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        // FADD timing and result
        v0 = valid_cnt;
        send(11'd0, 32'h3F800000, 32'h40000000, 1'b1, {1'b0, 32'h40400000}, a);
        wait_idle(100);
        check("fadd_valid_cyc", last_valid_cyc, a + 2);
        check("fadd_rv_cyc", last_rise_cyc, a + 7);
        check("fadd_issues", valid_cnt - v0, 1);

        // FMUL with a single acknowledge
        c0 = acc_cnt;
        send(11'd2, 32'h40000000, 32'h40400000, 1'b1, {1'b0, 32'h40C00000}, a);
        wait_idle(100);
        check("fmul_rv_cyc", last_rise_cyc, a + 9);
        check("fmul_acc_cyc", last_acc_cyc, a + 9);
        check("fmul_acc_count", acc_cnt - c0, 1);

        // Invalid opcode followed by FSUB
        v0 = valid_cnt;
        send(11'd5, 32'h00000001, 32'h00000002, 1'b1, {1'b1, 32'd0}, a1);
        send(11'd1, 32'h40400000, 32'h3F800000, 1'b1, {1'b0, 32'h40000000}, a2);
        check("inv_cyc_now", cyc, a1 + 2);
        check("inv_rv", res_valid, 1'b1);
        check("inv_err", res_err, 1'b1);
        check("inv_data", res_data, 32'd0);
        wait_idle(100);
        check("inv_issues", valid_cnt - v0, 1);
        check("fsub_valid_cyc", last_valid_cyc, a2 + 2);

        // Back-pressure: result FIFO full stops issue, command FIFO fills
        res_ready = 1'b0;
        v0 = valid_cnt;
        for (int i = 0; i < 8; i++) begin
            send(11'd0, 32'h1000 + i, 32'h20000 + i, 1'b1,
                 {1'b0, fp_model(11'd0, 32'h1000 + i, 32'h20000 + i)}, a);
        end
        repeat (60) @(posedge clk); #1;
        check("bp_cmd_ready", cmd_ready, 1'b0);
        check("bp_issues", valid_cnt - v0, 4);
        check("bp_res_valid", res_valid, 1'b1);
        check("bp_busy", busy, 1'b1);
        res_ready = 1'b1;
        for (int i = 8; i < 10; i++) begin
            send(11'd0, 32'h1000 + i, 32'h20000 + i, 1'b1,
                 {1'b0, fp_model(11'd0, 32'h1000 + i, 32'h20000 + i)}, a);
        end
        wait_idle(400);
        check("bp_total_issues", valid_cnt - v0, 10);

        // Coprocessor never completes
        stub_hang = 1'b1;
        c0 = acc_cnt;
        send(11'd0, 32'h3F800000, 32'h3F800000, 1'b1, {1'b1, 32'd0}, a);
        wait_idle(600);
        stub_hang = 1'b0;
        check("to_rv_cyc", last_rise_cyc, a + 3 + TO);
        check("to_acc_cyc", last_acc_cyc, a + 3 + TO);
        check("to_acc_count", acc_cnt - c0, 1);

        // Reset during WAIT, late completion flushed while idle
        lat_ovr = 20;
        c0 = acc_cnt; v0 = valid_cnt;
        send(11'd0, 32'h3F800000, 32'h40000000, 1'b0, {1'b0, 32'd0}, a);
        repeat (5) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_res_valid", res_valid, 1'b0);
        reset = 1'b0;
        a1 = rv_cnt;
        repeat (25) @(posedge clk); #1;
        lat_ovr = 0;
        check("flush_acc_count", acc_cnt - c0, 1);
        check("flush_acc_cyc", last_acc_cyc, a + 23);
        check("flush_no_result", rv_cnt - a1, 0);
        check("flush_issues", valid_cnt - v0, 1);
        check("flush_busy", busy, 1'b0);
        send(11'd0, 32'h3F800000, 32'h40000000, 1'b1, {1'b0, 32'h40400000}, a);
        wait_idle(100);
        check("post_flush_rv_cyc", last_rise_cyc, a + 7);

        repeat (3) @(posedge clk); #1;
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/copro_dispatch.md
# copro_dispatch

Issue stage between the LM32 user-instruction port and `float_copro`. It buffers floating-point commands in a command FIFO and issues them one at a time over the `copro_valid`/`copro_complete`/`copro_accept` handshake. Each result is captured into a result FIFO for the CPU, and the coprocessor is acknowledged afterwards. Opcodes the coprocessor cannot execute are filtered here, because `float_copro` never completes on them.

## Interface
- `CDEPTH`, default 4: command FIFO depth, power of 2, at least 2.
- `RDEPTH`, default 4: result FIFO depth, power of 2, at least 2.
- `TIMEOUT`, default 255: maximum number of WAIT cycles before an error result is forced.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: CPU command present.
- `cmd_ready` out 1: command FIFO can accept; equals `!full && !reset`.
- `cmd_opcode` in 11: operation code.
- `cmd_op0` in 32, `cmd_op1` in 32: IEEE-754 single-precision operands.
- `res_valid` out 1: result FIFO is not empty.
- `res_ready` in 1: CPU pops the head result.
- `res_data` out 32: head result.
- `res_err` out 1: head result is an error (bad opcode or timeout).
- `copro_valid` out 1: issue strobe to the coprocessor.
- `copro_accept` out 1: result acknowledge to the coprocessor.
- `copro_opcode` out 11, `copro_op0` out 32, `copro_op1` out 32: registered operands driven to the coprocessor.
- `copro_complete` in 1: coprocessor result ready.
- `copro_result` in 32: coprocessor result.
- `busy` out 1: high when the state is not IDLE or the command FIFO is not empty.

## Operation
- Reset values:
  - All FIFOs are empty and the state is IDLE.
  - `copro_valid`, `copro_accept`, `res_valid`, `res_err` and `busy` are 0.
  - `res_data`, `copro_opcode`, `copro_op0` and `copro_op1` are 0.
- Valid opcodes: 0 FADD, 1 FSUB, 2 FMUL, 3 FDIV. Any value of 4 or more is invalid.
- State machine (IDLE, ISSUE, WAIT, ACK):
  - IDLE, with `copro_complete`=1 (stale result after reset): drive `copro_accept`=1 for this cycle, pop nothing, stay in IDLE.
  - IDLE, otherwise: pop when the command FIFO is not empty and the result FIFO is not full.
    - Valid opcode: load the operand registers, go to ISSUE.
    - Invalid opcode: push {data 0, err 1}, stay in IDLE. `copro_valid` is never raised for it.
  - ISSUE: `copro_valid`=1 for exactly one cycle, then go to WAIT.
  - WAIT: a timeout counter increments each cycle.
    - On `copro_complete`=1: push {`copro_result`, err 0}, go to ACK.
    - When the counter reaches `TIMEOUT`: push {0, err 1}, go to ACK.
  - ACK: `copro_accept`=1 for one cycle, then go to IDLE.
- At most one operation is in flight at a time. The result FIFO is checked for space at pop time, so the later result push can never overflow it.
- Command FIFO full: `cmd_ready`=0, even if a pop happens in the same cycle.
- Result FIFO: push and pop in the same cycle are allowed; the count stays unchanged.
- Reset mid-operation: the operation is dropped and no result is produced for it. A late `copro_complete` is flushed by the IDLE accept rule.
- `copro_valid` and `copro_accept` are never high in the same cycle.

## Timing
- Command handshake completes at the end of cycle A. The command FIFO is non-empty and popped in A+1; ISSUE is in A+2.
- `float_copro` latches at the end of ISSUE. `copro_complete` is high in A+t+3, where t is that op's latency parameter.
- `res_valid` rises in A+t+4, with ACK in the same cycle.
  - Default latencies: FADD A+7, FSUB A+6, FMUL A+9, FDIV A+9.
- IDLE is re-entered in A+t+5. Issue-to-issue spacing is t+4 cycles.
- Invalid opcode: `res_valid` rises in A+2.

## Structure
- Package `copro_pkg` holds:
  - opcode constants `OP_FADD`..`OP_FDIV` and `OP_LAST`=3;
  - the `dispatch_state_t` enum;
  - the 11-bit opcode width.
- Sub-module `copro_fifo` is parameterised by width and depth, with an asynchronous-reset pointer/count FIFO. It is instantiated twice:
  - commands: 75 bits wide;
  - results: 33 bits wide.

## Test plan
- FADD 0x3F800000 + 0x40000000 with `float_copro` at defaults, handshake in cycle A → `copro_valid` in A+2, `res_data`=0x40400000, `res_err`=0, `res_valid` in A+7.
- FMUL 0x40000000 × 0x40400000 → 0x40C00000 in A+9. A single `copro_accept` pulse occurs in A+9.
- Opcode 5, then FSUB 0x40400000 − 0x3F800000 → first result {0, err 1} in A+2 with no `copro_valid`; then 0x40000000.
- `res_ready`=0 while pushing 10 FADDs → after 4 results, no further `copro_valid`. `cmd_ready` drops once the command FIFO holds 4. Raising `res_ready` drains all 10 in order.
- Coprocessor stub never completes → {0, err 1} after 255 WAIT cycles, then ACK, then IDLE.
- Reset asserted in WAIT, stub completes afterwards → after reset, IDLE pulses `copro_accept` and pushes no result. The next FADD completes normally.
